prefetch_fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the pipelined mini CPU. It owns the instruction memory and its program-load port, and fetches sequentially from a programmable start PC through a prefetch FIFO. It delivers {pc, instruction, fault} to decode over a valid/ready handshake and supports stall, pause and PC redirect (branch/jump flush).

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/prefetch_fetch_unit_if.sv | 39 +++
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/prefetch_fetch_unit.sv | 169 ++++++++++++++++
 tb/tb_prefetch_fetch_unit.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the prefetch fetch unit: FSM states, the
// prefetch FIFO entry and the sequential-PC helper.
package fetch_pkg;

  localparam int ENTRY_XLEN = 32;

  localparam logic [ENTRY_XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [ENTRY_XLEN-1:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    FAULT = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [ENTRY_XLEN-1:0] pc;
    logic [ENTRY_XLEN-1:0] instr;
    logic                  fault;
  } fetch_entry_t;

  function automatic logic [ENTRY_XLEN-1:0] next_pc(input logic [ENTRY_XLEN-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/prefetch_fetch_unit_if.sv
// Program-load, fetch-control and decode-side handshake bundle of the fetch unit.
// The master drives loads, control and out_ready; the slave is the fetch unit.
interface prefetch_fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int XLEN = ENTRY_XLEN
) ();

  logic            load_enable;
  logic [XLEN-1:0] load_address;
  logic [XLEN-1:0] load_data;
  logic            load_error;

  logic            fetch_enable;
  logic [XLEN-1:0] base_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic            out_fault;

  modport master (
    output load_enable, load_address, load_data,
    output fetch_enable, base_pc, redirect_valid, redirect_pc,
    output out_ready,
    input  load_error, out_valid, out_pc, out_instr, out_fault
  );

  modport slave (
    input  load_enable, load_address, load_data,
    input  fetch_enable, base_pc, redirect_valid, redirect_pc,
    input  out_ready,
    output load_error, out_valid, out_pc, out_instr, out_fault
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch entries with push, pop, single-cycle flush and occupancy count.
// The head entry is presented straight from the storage registers.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int FIFO_DEPTH = 4,
  localparam int PW         = $clog2(FIFO_DEPTH),
  localparam int CW         = PW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  fetch_entry_t  push_data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output fetch_entry_t  head_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  entries_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_pop_s;

  // Popping an empty FIFO is silently ignored.
  assign do_pop_s = pop_i && (count_q != '0);

  // Storage, pointers and occupancy; flush clears the pointers but leaves stale data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        entries_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q            <= wr_ptr_q + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push_i, do_pop_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = entries_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/prefetch_fetch_unit.sv
// Instruction fetch front end: instruction memory with program-load port, fetch FSM,
// single in-flight read tracking and the prefetch FIFO feeding decode.
module prefetch_fetch_unit
  import fetch_pkg::*;
#(
  parameter int XLEN       = ENTRY_XLEN,
  parameter int IMEM_DEPTH = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  prefetch_fetch_unit_if.slave bus
);

  localparam int            AW         = $clog2(IMEM_DEPTH);
  localparam int            CW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]   FIFO_LIMIT = (CW + 1)'(FIFO_DEPTH);

  logic [XLEN-1:0] mem_q [IMEM_DEPTH];
  logic [XLEN-1:0] rdata_q;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            inflight_q;
  logic            infl_fault_q;
  logic [XLEN-1:0] infl_pc_q;
  logic            load_error_q;

  logic            load_ok_s;
  logic            pc_ok_s;
  logic            flush_s;
  logic            room_s;
  logic            push_s;
  logic            pop_s;
  logic            issue_s;
  logic            issue_fault_s;
  logic            fifo_empty_s;
  logic [CW-1:0]   fifo_count_s;
  fetch_entry_t    push_entry_s;
  fetch_entry_t    head_s;

  function automatic logic word_addr_ok(input logic [XLEN-1:0] addr);
    return (addr[1:0] == 2'b00) && ((addr >> (AW + 2)) == '0);
  endfunction

  assign load_ok_s = bus.load_enable && word_addr_ok(bus.load_address);
  assign pc_ok_s   = word_addr_ok(fetch_pc_q);
  assign flush_s   = (state_q != IDLE) && (bus.load_enable || bus.redirect_valid);
  assign room_s    = ({1'b0, fifo_count_s} + {{CW{1'b0}}, inflight_q}) < FIFO_LIMIT;

  // A flush kills the returning read; a redirect also discards the head instead of consuming it.
  assign push_s = inflight_q && !flush_s;
  assign pop_s  = !fifo_empty_s && bus.out_ready && !flush_s;

  assign push_entry_s = '{pc:    infl_pc_q,
                          instr: (infl_fault_q ? NOP_INSTR : rdata_q),
                          fault: infl_fault_q};

  // Next fetch state and PC; load and redirect override the per-state decision.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    issue_s       = 1'b0;
    issue_fault_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.fetch_enable && !bus.load_enable) begin
          state_d    = RUN;
          fetch_pc_d = bus.base_pc;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (!bus.fetch_enable) begin
          state_d = PAUSE;
        end else if (room_s && pc_ok_s) begin
          issue_s    = 1'b1;
          fetch_pc_d = next_pc(fetch_pc_q);
        end else if (room_s) begin
          // The fault entry travels through the in-flight slot so it keeps read timing.
          issue_fault_s = 1'b1;
          state_d       = FAULT;
        end else begin
          state_d = RUN;
        end
      end
      PAUSE: begin
        if (bus.fetch_enable) begin
          state_d = RUN;
        end else begin
          state_d = PAUSE;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if ((state_q != IDLE) && bus.load_enable) begin
      state_d       = IDLE;
      fetch_pc_d    = fetch_pc_q;
      issue_s       = 1'b0;
      issue_fault_s = 1'b0;
    end else if ((state_q != IDLE) && bus.redirect_valid) begin
      state_d       = bus.fetch_enable ? RUN : PAUSE;
      fetch_pc_d    = bus.redirect_pc;
      issue_s       = 1'b0;
      issue_fault_s = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  // FSM state, fetch PC, in-flight slot and load-error pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      fetch_pc_q   <= '0;
      inflight_q   <= 1'b0;
      infl_fault_q <= 1'b0;
      infl_pc_q    <= '0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      inflight_q   <= issue_s || issue_fault_s;
      load_error_q <= bus.load_enable && !load_ok_s;
      if (issue_s || issue_fault_s) begin
        infl_pc_q    <= fetch_pc_q;
        infl_fault_q <= issue_fault_s;
      end
    end
  end

  // Instruction memory: not reset, so a loaded program survives reset_n.
  always_ff @(posedge clk) begin
    if (load_ok_s) begin
      mem_q[bus.load_address[AW+1:2]] <= bus.load_data;
    end
    if (issue_s) begin
      rdata_q <= mem_q[fetch_pc_q[AW+1:2]];
    end
  end

  fetch_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_ni      (reset_n),
    .push_i      (push_s),
    .push_data_i (push_entry_s),
    .pop_i       (pop_s),
    .flush_i     (flush_s),
    .head_o      (head_s),
    .empty_o     (fifo_empty_s),
    .count_o     (fifo_count_s)
  );

  assign bus.load_error = load_error_q;
  assign bus.out_valid  = !fifo_empty_s;
  assign bus.out_pc     = head_s.pc;
  assign bus.out_instr  = head_s.instr;
  assign bus.out_fault  = head_s.fault;

endmodule

// File: tb/tb_prefetch_fetch_unit.sv
// Bench for prefetch_fetch_unit: table-driven load vectors, directed latency/corner
// sequences and a randomized phase scored against a stream-level fetch model.
module tb_prefetch_fetch_unit;
  import fetch_pkg::*;

  localparam int          XLEN       = 32;
  localparam int          IMEM_DEPTH = 256;
  localparam int          FIFO_DEPTH = 4;
  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [31:0] I0         = 32'h0050_0093;
  localparam logic [31:0] I1         = 32'h00A0_0113;
  localparam logic [31:0] I2         = 32'h0020_81B3;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;

  prefetch_fetch_unit_if #(.XLEN(XLEN)) bus ();

  prefetch_fetch_unit #(
    .XLEN       (XLEN),
    .IMEM_DEPTH (IMEM_DEPTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        exp_err;
  } load_vec_t;

  load_vec_t   lv [7];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_acc    = 0;
  logic [31:0] mem_m [IMEM_DEPTH];
  logic        idle_m    = 1'b1;
  logic        dead_m    = 1'b0;
  logic        exp_err_m = 1'b0;
  logic [31:0] exp_pc_m  = 32'd0;
  logic [31:0] last_pc   = 32'd0;

  function automatic logic legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a < IMEM_DEPTH * 4);
  endfunction

  function automatic logic [31:0] pattern(input int i);
    return 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0101);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stream model: an accepted entry must be the next sequential pc since the last (re)start.
  task automatic accept();
    logic        f;
    logic [31:0] ei;
    n_acc++;
    if (dead_m) begin
      chk("entry_after_fault", {31'd0, bus.out_valid}, 32'd0);
    end else begin
      f  = !legal(exp_pc_m);
      ei = f ? NOP : mem_m[exp_pc_m / 4];
      chk("sb_pc", bus.out_pc, exp_pc_m);
      chk("sb_instr", bus.out_instr, ei);
      chk("sb_fault", {31'd0, bus.out_fault}, {31'd0, f});
      last_pc = bus.out_pc;
      if (f) dead_m = 1'b1;
      else   exp_pc_m = exp_pc_m + 32'd4;
    end
  endtask

  // One clock: score the handshake seen before the edge, then sample #1 after it.
  task automatic tick();
    if (!reset_n) begin
      idle_m    = 1'b1;
      dead_m    = 1'b0;
      exp_err_m = 1'b0;
    end else if (bus.load_enable) begin
      exp_err_m = !legal(bus.load_address);
      if (!exp_err_m) mem_m[bus.load_address / 4] = bus.load_data;
      idle_m = 1'b1;
    end else begin
      exp_err_m = 1'b0;
      if (idle_m) begin
        if (bus.fetch_enable) begin
          idle_m   = 1'b0;
          dead_m   = 1'b0;
          exp_pc_m = bus.base_pc;
        end
      end else if (bus.redirect_valid) begin
        exp_pc_m = bus.redirect_pc;
        dead_m   = 1'b0;
      end else if (bus.out_valid && bus.out_ready) begin
        accept();
      end
    end
    @(posedge clk);
    #1;
    chk("load_error", {31'd0, bus.load_error}, {31'd0, exp_err_m});
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] d);
    bus.load_enable  = 1'b1;
    bus.load_address = a;
    bus.load_data    = d;
    tick();
    bus.load_enable  = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    tick();
    bus.redirect_valid = 1'b0;
  endtask

  task automatic chk_out(input string name, input logic v, input logic [31:0] pc,
                         input logic [31:0] ins, input logic f);
    chk({name, "_valid"}, {31'd0, bus.out_valid}, {31'd0, v});
    if (v) begin
      chk({name, "_pc"}, bus.out_pc, pc);
      chk({name, "_instr"}, bus.out_instr, ins);
      chk({name, "_fault"}, {31'd0, bus.out_fault}, {31'd0, f});
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({name, "_pc"}, bus.out_pc, 32'd0);
    chk({name, "_instr"}, bus.out_instr, 32'd0);
    chk({name, "_fault"}, {31'd0, bus.out_fault}, 32'd0);
    chk({name, "_lerr"}, {31'd0, bus.load_error}, 32'd0);
  endtask

  initial begin
    lv[0] = '{32'h0000_0000, I0, 1'b0};
    lv[1] = '{32'h0000_0004, I1, 1'b0};
    lv[2] = '{32'h0000_0008, I2, 1'b0};
    lv[3] = '{32'h0000_0002, 32'hDEAD_BEEF, 1'b1};
    lv[4] = '{32'h0000_0400, 32'hDEAD_BEEF, 1'b1};
    lv[5] = '{32'h8000_0000, 32'hDEAD_BEEF, 1'b1};
    lv[6] = '{32'h0000_0003, 32'hDEAD_BEEF, 1'b1};

    bus.load_enable    = 1'b0;
    bus.load_address   = 32'd0;
    bus.load_data      = 32'd0;
    bus.fetch_enable   = 1'b0;
    bus.base_pc        = 32'd0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    bus.out_ready      = 1'b0;

    #1 reset_n = 1'b0;
    #20;
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < IMEM_DEPTH; i++) begin
      do_load(32'(i) * 32'd4, pattern(i));
    end

    // Table-driven program load and rejected loads.
    for (int k = 0; k < 7; k++) begin
      bus.load_enable  = 1'b1;
      bus.load_address = lv[k].addr;
      bus.load_data    = lv[k].data;
      tick();
      chk("load_vec_err", {31'd0, bus.load_error}, {31'd0, lv[k].exp_err});
    end
    bus.load_enable = 1'b0;
    tick();
    chk("load_err_single_pulse", {31'd0, bus.load_error}, 32'd0);

    // Start latency and back-to-back delivery; rejected loads must not have altered word 0.
    bus.fetch_enable = 1'b1;
    bus.base_pc      = 32'd0;
    bus.out_ready    = 1'b1;
    tick();
    chk_out("start_n", 1'b0, 32'd0, 32'd0, 1'b0);
    tick();
    chk_out("start_n1", 1'b0, 32'd0, 32'd0, 1'b0);
    tick();
    chk_out("start_pc0", 1'b1, 32'd0, I0, 1'b0);
    tick();
    chk_out("start_pc4", 1'b1, 32'd4, I1, 1'b0);
    tick();
    chk_out("start_pc8", 1'b1, 32'd8, I2, 1'b0);

    // Consumer stall: head held, FIFO fills, then gap-free drain.
    bus.out_ready = 1'b0;
    redirect_to(32'd0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k >= 2) chk_out("stall_hold", 1'b1, 32'd0, I0, 1'b0);
      else        chk_out("stall_gap", 1'b0, 32'd0, 32'd0, 1'b0);
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("drain_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("drain_pc", bus.out_pc, 32'(k) * 32'd4);
      tick();
    end

    // Redirect beats a same-cycle pop of pc 0.
    bus.out_ready = 1'b0;
    redirect_to(32'd0);
    tick();
    tick();
    tick();
    chk_out("pre_redirect_head", 1'b1, 32'd0, I0, 1'b0);
    bus.out_ready = 1'b1;
    redirect_to(32'd8);
    chk_out("redir_m", 1'b0, 32'd0, 32'd0, 1'b0);
    tick();
    chk_out("redir_m1", 1'b0, 32'd0, 32'd0, 1'b0);
    tick();
    chk_out("redir_m2", 1'b1, 32'd8, I2, 1'b0);

    // Fetch running off the end of memory.
    do_load(32'd12, pattern(3));
    bus.base_pc = 32'(IMEM_DEPTH - 1) * 32'd4;
    tick();
    tick();
    chk_out("end_gap", 1'b0, 32'd0, 32'd0, 1'b0);
    tick();
    chk_out("end_last", 1'b1, 32'(IMEM_DEPTH - 1) * 32'd4, pattern(IMEM_DEPTH - 1), 1'b0);
    tick();
    chk_out("end_fault", 1'b1, 32'(IMEM_DEPTH) * 32'd4, NOP, 1'b1);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("fault_quiet", {31'd0, bus.out_valid}, 32'd0);
    end
    redirect_to(32'd0);
    tick();
    tick();
    chk_out("fault_recover", 1'b1, 32'd0, I0, 1'b0);

    // Pause mid-stream resumes at the next sequential pc.
    tick();
    tick();
    tick();
    bus.fetch_enable = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("pause_drained", {31'd0, bus.out_valid}, 32'd0);
    bus.fetch_enable = 1'b1;
    tick();
    tick();
    chk("resume_gap", {31'd0, bus.out_valid}, 32'd0);
    tick();
    chk("resume_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("resume_pc", bus.out_pc, last_pc + 32'd4);
    for (int k = 0; k < 4; k++) tick();

    // Asynchronous reset mid-stream; memory must survive it.
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    tick();
    chk_reset_outputs("midreset_held");
    reset_n     = 1'b1;
    bus.base_pc = 32'd0;
    tick();
    tick();
    tick();
    chk_out("post_reset_pc0", 1'b1, 32'd0, I0, 1'b0);

    // Randomized traffic scored by the stream model.
    n_acc       = 0;
    bus.base_pc = 32'h40;
    for (int c = 0; c < 4000; c++) begin
      int r;
      int sel;
      r   = $urandom_range(0, 255);
      sel = $urandom_range(0, 9);
      bus.out_ready      = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = (r < 8);
      if (sel < 8)       bus.redirect_pc = 32'($urandom_range(0, IMEM_DEPTH - 1)) * 32'd4;
      else if (sel == 8) bus.redirect_pc = 32'h0000_03E0;
      else               bus.redirect_pc = $urandom;
      bus.load_enable = (r == 8) || (r == 9);
      bus.load_data   = $urandom;
      if (r == 8)                       bus.load_address = 32'($urandom_range(0, IMEM_DEPTH - 1)) * 32'd4;
      else if ($urandom_range(0, 1) == 0) bus.load_address = 32'($urandom_range(0, IMEM_DEPTH - 1)) * 32'd4 + 32'd2;
      else                              bus.load_address = 32'h400 + 32'($urandom_range(0, 255)) * 32'd4;
      if ($urandom_range(0, 15) == 0) bus.fetch_enable = !bus.fetch_enable;
      tick();
    end
    bus.load_enable    = 1'b0;
    bus.redirect_valid = 1'b0;
    tick();
    chk("random_progress", {31'd0, n_acc > 200}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
